// File: rtl/iccm_boot_seq.sv
// ICCM boot sequencer: hands the ICCM port to the selected loader while the
// core is held in reset, then releases the core and gives it the port.
module iccm_boot_seq #(
   parameter int unsigned ADDR_W    = 14,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned DEPTH     = 16384,
   parameter int unsigned DRAIN_CYC = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              boot_sel_i,
   input  logic              uart_we_i,
   input  logic [ADDR_W-1:0] uart_addr_i,
   input  logic [DATA_W-1:0] uart_wdata_i,
   input  logic              uart_done_i,
   input  logic              spi_we_i,
   input  logic [ADDR_W-1:0] spi_addr_i,
   input  logic [DATA_W-1:0] spi_wdata_i,
   input  logic              spi_done_i,
   input  logic              core_req_i,
   input  logic [ADDR_W-1:0] core_addr_i,
   output logic              core_gnt_o,
   output logic              core_rvalid_o,
   output logic [DATA_W-1:0] core_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              core_rst_no,
   output logic              boot_done_o,
   output logic [ADDR_W:0]   word_count_o,
   output logic [DATA_W-1:0] checksum_o,
   output logic              error_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_RUN   = 2'd3;

   localparam int unsigned CNT_W =
      (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYC - 1);
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] WC_MAX = {1'b1, {ADDR_W{1'b0}}};

   logic [1:0]        state_q, state_d;
   logic              sel_q, sel_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [ADDR_W:0]   wc_q, wc_d;
   logic [DATA_W-1:0] cs_q, cs_d;
   logic              err_q, err_d;
   logic              run_q, run_d;
   logic              rvalid_q, rvalid_d;

   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_done;
   logic              oth_we;
   logic              in_range;
   logic              any_we;

   // Route the chosen loader; the other one only matters as an error source.
   always_comb begin
      sel_we    = sel_q ? uart_we_i    : spi_we_i;
      sel_addr  = sel_q ? uart_addr_i  : spi_addr_i;
      sel_wdata = sel_q ? uart_wdata_i : spi_wdata_i;
      sel_done  = sel_q ? uart_done_i  : spi_done_i;
      oth_we    = sel_q ? spi_we_i     : uart_we_i;
      in_range  = ({1'b0, sel_addr} < DEPTH_L);
      any_we    = uart_we_i | spi_we_i;
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      wr_d     = 1'b0;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      wc_d     = wc_q;
      cs_d     = cs_q;
      err_d    = err_q;
      run_d    = run_q;
      rvalid_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            sel_d   = boot_sel_i;
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (sel_we && in_range) begin
               wr_d    = 1'b1;
               waddr_d = sel_addr;
               wdata_d = sel_wdata;
               wc_d    = (wc_q == WC_MAX) ? wc_q : wc_q + 1'b1;
               cs_d    = cs_q + sel_wdata;
            end
            if ((sel_we && !in_range) || oth_we) begin
               err_d = 1'b1;
            end
            if (sel_done) begin
               state_d = ST_DRAIN;
               cnt_d   = '0;
            end
         end
         ST_DRAIN: begin
            if (any_we) begin
               err_d = 1'b1;
            end
            if (cnt_q == CNT_LAST) begin
               state_d = ST_RUN;
               run_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (any_we) begin
               err_d = 1'b1;
            end
            rvalid_d = core_req_i;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         sel_q    <= 1'b0;
         cnt_q    <= '0;
         wr_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         wc_q     <= '0;
         cs_q     <= '0;
         err_q    <= 1'b0;
         run_q    <= 1'b0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         wr_q     <= wr_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         wc_q     <= wc_d;
         cs_q     <= cs_d;
         err_q    <= err_d;
         run_q    <= run_d;
         rvalid_q <= rvalid_d;
      end
   end

   // After boot the core owns the port through a zero-latency passthrough.
   always_comb begin
      core_gnt_o    = run_q & core_req_i;
      mem_req_o     = run_q ? core_req_i  : wr_q;
      mem_we_o      = run_q ? 1'b0        : wr_q;
      mem_addr_o    = run_q ? core_addr_i : waddr_q;
      mem_wdata_o   = run_q ? '0          : wdata_q;
      core_rvalid_o = rvalid_q;
      core_rdata_o  = rvalid_q ? mem_rdata_i : '0;
      core_rst_no   = run_q;
      boot_done_o   = run_q;
      word_count_o  = wc_q;
      checksum_o    = cs_q;
      error_o       = err_q;
   end

endmodule

// File: tb/tb_iccm_boot_seq.sv
// Scoreboard bench for iccm_boot_seq: a loader/core model predicts ICCM
// writes and fetch data, a monitor compares them as the DUT presents them.
module tb_iccm_boot_seq;

   localparam int AW = 15;
   localparam int DW = 32;
   localparam int DEPTH = 16384;
   localparam int DC = 4;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          boot_sel_i = 1'b0;
   logic          uart_we_i = 1'b0;
   logic [AW-1:0] uart_addr_i = '0;
   logic [DW-1:0] uart_wdata_i = '0;
   logic          uart_done_i = 1'b0;
   logic          spi_we_i = 1'b0;
   logic [AW-1:0] spi_addr_i = '0;
   logic [DW-1:0] spi_wdata_i = '0;
   logic          spi_done_i = 1'b0;
   logic          core_req_i = 1'b0;
   logic [AW-1:0] core_addr_i = '0;
   logic          core_gnt_o;
   logic          core_rvalid_o;
   logic [DW-1:0] core_rdata_o;
   logic          mem_req_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic [DW-1:0] mem_rdata_i = '0;
   logic          core_rst_no;
   logic          boot_done_o;
   logic [AW:0]   word_count_o;
   logic [DW-1:0] checksum_o;
   logic          error_o;

   always #5 clk_i = ~clk_i;

   iccm_boot_seq #(
      .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .DRAIN_CYC(DC)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .boot_sel_i(boot_sel_i),
      .uart_we_i(uart_we_i), .uart_addr_i(uart_addr_i),
      .uart_wdata_i(uart_wdata_i), .uart_done_i(uart_done_i),
      .spi_we_i(spi_we_i), .spi_addr_i(spi_addr_i),
      .spi_wdata_i(spi_wdata_i), .spi_done_i(spi_done_i),
      .core_req_i(core_req_i), .core_addr_i(core_addr_i),
      .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
      .core_rdata_o(core_rdata_o), .mem_req_o(mem_req_o),
      .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
      .core_rst_no(core_rst_no), .boot_done_o(boot_done_o),
      .word_count_o(word_count_o), .checksum_o(checksum_o),
      .error_o(error_o)
   );

   // ICCM behavioural memory
   logic [DW-1:0] mem [0:DEPTH-1];
   always @(posedge clk_i) begin
      if (mem_req_o && !mem_addr_o[AW-1]) begin
         if (mem_we_o) mem[mem_addr_o[AW-2:0]] <= mem_wdata_o;
         else mem_rdata_i <= mem[mem_addr_o[AW-2:0]];
      end
   end

   // reference model state
   bit [DW-1:0] img [int];
   int unsigned m_wc;
   bit [DW-1:0] m_cs;
   bit m_err, m_load, m_post, m_sel;
   logic [AW-1:0] qa [$];
   logic [DW-1:0] qd [$];
   logic [DW-1:0] qr [$];
   int tests = 0;
   int fails = 0;

   task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (mem_req_o && mem_we_o) begin
            if (qa.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_write: addr %0h data %0h expected none",
                        mem_addr_o, mem_wdata_o);
            end else begin
               chk("wr_addr", 64'(mem_addr_o), 64'(qa.pop_front()));
               chk("wr_data", 64'(mem_wdata_o), 64'(qd.pop_front()));
            end
         end
         if (core_rvalid_o) begin
            if (qr.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_rvalid: data %0h expected none",
                        core_rdata_o);
            end else begin
               chk("rd_data", 64'(core_rdata_o), 64'(qr.pop_front()));
            end
         end
      end
   end

   task automatic cyc(bit uwe, logic [AW-1:0] ua, logic [DW-1:0] ud,
                      bit swe, logic [AW-1:0] sa, logic [DW-1:0] sd,
                      bit udn, bit sdn);
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      bit we, owe, dn;
      @(negedge clk_i);
      uart_we_i = uwe; uart_addr_i = ua; uart_wdata_i = ud;
      spi_we_i = swe; spi_addr_i = sa; spi_wdata_i = sd;
      uart_done_i = udn; spi_done_i = sdn;
      core_req_i = 1'b0;
      boot_sel_i = 1'($urandom);
      a = m_sel ? ua : sa;
      d = m_sel ? ud : sd;
      we = m_sel ? uwe : swe;
      owe = m_sel ? swe : uwe;
      dn = m_sel ? udn : sdn;
      if (m_load) begin
         if (we) begin
            if (int'(a) < DEPTH) begin
               qa.push_back(a); qd.push_back(d);
               img[int'(a)] = d;
               if (m_wc < (1 << AW)) m_wc++;
               m_cs += d;
            end else m_err = 1;
         end
         if (owe) m_err = 1;
         if (dn) begin m_load = 0; m_post = 1; end
      end else if (m_post && (uwe || swe)) m_err = 1;
   endtask

   task automatic idle();
      cyc(0, '0, '0, 0, '0, '0, 0, 0);
   endtask

   task automatic rst_chk();
      core_req_i = 1'b1;
      #1;
      chk("rst_core_rst_no", 64'(core_rst_no), 0);
      chk("rst_boot_done", 64'(boot_done_o), 0);
      chk("rst_word_count", 64'(word_count_o), 0);
      chk("rst_checksum", 64'(checksum_o), 0);
      chk("rst_error", 64'(error_o), 0);
      chk("rst_mem_req", 64'(mem_req_o), 0);
      chk("rst_mem_we", 64'(mem_we_o), 0);
      chk("rst_mem_addr", 64'(mem_addr_o), 0);
      chk("rst_mem_wdata", 64'(mem_wdata_o), 0);
      chk("rst_gnt", 64'(core_gnt_o), 0);
      chk("rst_rvalid", 64'(core_rvalid_o), 0);
      chk("rst_rdata", 64'(core_rdata_o), 0);
      core_req_i = 1'b0;
   endtask

   task automatic rst_pulse();
      #2;
      rst_ni = 1'b0;
      qa.delete(); qd.delete(); qr.delete();
      rst_chk();
   endtask

   task automatic boot(bit sel);
      @(negedge clk_i);
      boot_sel_i = sel;
      rst_ni = 1'b1;
      m_sel = sel; m_wc = 0; m_cs = 0; m_err = 0;
      m_load = 1; m_post = 0;
   endtask

   task automatic drain_run(bit inject);
      int n = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_i);
         uart_we_i = 0; spi_we_i = 0;
         uart_done_i = 0; spi_done_i = 0;
         if (inject && i == 1) begin
            spi_we_i = 1; uart_we_i = 1; m_err = 1;
         end
         if (core_rst_no) break;
         n++;
      end
      uart_we_i = 0; spi_we_i = 0;
      chk("drain_cycles", 64'(n), 64'(DC));
      chk("boot_done", 64'(boot_done_o), 1);
   endtask

   task automatic chk_stats(string tag);
      chk({tag, "_word_count"}, 64'(word_count_o), 64'(m_wc));
      chk({tag, "_checksum"}, 64'(checksum_o), 64'(m_cs));
      chk({tag, "_error"}, 64'(error_o), 64'(m_err));
   endtask

   task automatic rd(logic [AW-1:0] a);
      @(negedge clk_i);
      uart_we_i = 0; spi_we_i = 0;
      core_req_i = 1'b1;
      core_addr_i = a;
      qr.push_back(img.exists(int'(a)) ? img[int'(a)] : '0);
      #1;
      chk("rd_gnt", 64'(core_gnt_o), 1);
      chk("rd_mem_req", 64'(mem_req_o), 1);
      chk("rd_mem_we", 64'(mem_we_o), 0);
      chk("rd_mem_addr", 64'(mem_addr_o), 64'(a));
   endtask

   task automatic rand_reads(int n, int amax);
      for (int i = 0; i < n; i++) begin
         rd(AW'($urandom_range(amax, 0)));
         if ($urandom_range(2, 0) == 0) idle();
      end
      idle(); idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      #12;
      rst_chk();

      // UART boot, three writes then done
      boot(1);
      cyc(1, 0, 32'h11, 0, '0, '0, 0, 0);
      cyc(1, 1, 32'h22, 0, '0, '0, 0, 0);
      cyc(1, 2, 32'h33, 0, '0, '0, 0, 0);
      cyc(0, '0, '0, 0, '0, '0, 1, 0);
      drain_run(0);
      chk("uart_wc3", 64'(word_count_o), 3);
      chk("uart_cs66", 64'(checksum_o), 64'h66);
      chk_stats("uart");
      rd(0); rd(1); rd(2);
      idle();
      rand_reads(12, 9);
      cyc(1, 3, 32'hdead, 0, '0, '0, 0, 0);
      idle();
      chk("run_write_error", 64'(error_o), 1);
      rst_pulse();

      // UART boot interrupted by reset after two writes
      boot(1);
      cyc(1, 4, $urandom, 0, '0, '0, 0, 0);
      cyc(1, 5, $urandom, 0, '0, '0, 0, 0);
      idle(); idle();
      chk_stats("midload");
      rst_pulse();

      // SPI boot with stray UART writes and out-of-range writes
      boot(0);
      cyc(1, 5, 32'hbad0, 0, '0, '0, 0, 0);
      idle();
      chk("spi_uart_inject_err", 64'(error_o), 1);
      chk_stats("spi_inject");
      for (int i = 0; i < 40; i++) begin
         logic [AW-1:0] sa;
         sa = ($urandom_range(9, 0) == 0) ?
              AW'($urandom_range(32767, DEPTH)) : AW'($urandom_range(63, 0));
         cyc($urandom_range(9, 0) == 0, AW'($urandom_range(63, 0)), $urandom,
             $urandom_range(3, 0) != 0, sa, $urandom, 0, 0);
      end
      cyc(0, '0, '0, 1, AW'(DEPTH), 32'h5a5a5a5a, 0, 0);
      idle();
      chk_stats("spi_oor");
      cyc(0, '0, '0, 1, 40, $urandom, 1, 0);
      cyc(0, '0, '0, 1, 41, $urandom, 0, 1);
      drain_run(1);
      chk_stats("spi_run");
      rand_reads(20, 63);
      rst_pulse();

      // write and done together, checksum wraps to zero
      boot(1);
      cyc(1, 3, 32'h1, 0, '0, '0, 0, 0);
      cyc(1, 7, 32'hffffffff, 0, '0, '0, 1, 0);
      drain_run(0);
      chk("wrap_checksum", 64'(checksum_o), 0);
      chk("wrap_wc", 64'(word_count_o), 2);
      chk_stats("wrap");
      rd(7); rd(3); rd(0);
      idle();
      rand_reads(10, 63);

      chk("wr_queue_empty", 64'(qa.size()), 0);
      chk("rd_queue_empty", 64'(qr.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/iccm_boot_seq.md
# iccm_boot_seq

Boot sequencer and port owner for the ICCM. After reset it hands the ICCM write port to the selected program loader (UART or SPI), keeps the core in reset while the image is written, and tracks word count and an additive checksum. When the loader signals completion, it waits a fixed drain interval, releases core reset, and from then on gives the ICCM port to the core's instruction fetch.

## Interface
Parameters:
- ADDR_W, 14, ICCM word-address width.
- DATA_W, 32, ICCM word width.
- DEPTH, 16384, number of valid ICCM words; valid addresses are 0..DEPTH-1.
- DRAIN_CYC, 4, cycles spent in DRAIN before core release (≥1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- boot_sel_i  in  1  loader select, 0 = SPI, 1 = UART; sampled once in IDLE.
- uart_we_i / uart_addr_i / uart_wdata_i  in  1 / ADDR_W / DATA_W  UART loader write.
- uart_done_i  in  1  UART loader image complete (level).
- spi_we_i / spi_addr_i / spi_wdata_i  in  1 / ADDR_W / DATA_W  SPI loader write.
- spi_done_i  in  1  SPI loader image complete (level).
- core_req_i  in  1  core fetch request.
- core_addr_i  in  ADDR_W  core fetch word address.
- core_gnt_o  out  1  fetch accepted.
- core_rvalid_o  out  1  fetch data valid.
- core_rdata_o  out  DATA_W  fetch data.
- mem_req_o / mem_we_o / mem_addr_o / mem_wdata_o  out  1 / 1 / ADDR_W / DATA_W  ICCM port.
- mem_rdata_i  in  DATA_W  ICCM read data, valid 1 cycle after a read request.
- core_rst_no  out  1  core reset, active-low.
- boot_done_o  out  1  high in RUN.
- word_count_o  out  ADDR_W+1  accepted loader writes.
- checksum_o  out  DATA_W  sum of accepted write data, mod 2^DATA_W.
- error_o  out  1  sticky error flag.

## Operation
- Reset values: state IDLE; mem_req_o, mem_we_o, core_gnt_o, core_rvalid_o, boot_done_o, error_o = 0; core_rst_no = 0; mem_addr_o, mem_wdata_o, core_rdata_o, word_count_o, checksum_o = 0; sel_q = 0.
- States: IDLE(0), LOAD(1), DRAIN(2), RUN(3).
- IDLE: latch sel_q <= boot_sel_i, then go to LOAD on the next cycle. boot_sel_i is ignored after this point.
- LOAD: a write from the selected loader with we=1 and addr<DEPTH is accepted:
  - registered into mem_req_o=1, mem_we_o=1, mem_addr_o, mem_wdata_o;
  - word_count += 1, saturating at 2^ADDR_W;
  - checksum += wdata.
- LOAD, rejected writes:
  - selected write with addr≥DEPTH is dropped and sets error_o;
  - any we=1 from the unselected loader is dropped and sets error_o.
- LOAD exit: the selected done_i=1 moves to DRAIN. A write in the same cycle is still accepted. The unselected done is ignored.
- DRAIN: no memory access; a counter runs 0..DRAIN_CYC-1, then the FSM goes to RUN. Loader writes in DRAIN are dropped and set error_o.
- RUN: core_rst_no=1 and boot_done_o=1, both registered.
  - core_gnt_o = core_req_i, combinational.
  - mem_req_o=core_req_i, mem_we_o=0, mem_addr_o=core_addr_i, combinational passthrough.
  - core_rvalid_o goes high 1 cycle after gnt; core_rdata_o = mem_rdata_i.
  - Loader writes are dropped and set error_o.
  - The FSM stays in RUN until reset.
- error_o clears only on reset and does not alter state flow.
- word_count_o and checksum_o hold their values after LOAD.

## Timing
- Loader write accepted at edge N drives mem_* during cycle N+1; one-cycle latency, one write per cycle sustained.
- mem_req_o/mem_we_o fall in the cycle after the last accepted write, unless a new write is accepted.
- Cycle counts from reset deassertion:
  - IDLE: 1 cycle.
  - DRAIN: exactly DRAIN_CYC cycles.
  - core_rst_no rises on the same edge the FSM enters RUN.
- Core read: gnt and request in cycle N, rvalid and rdata in N+1, back-to-back allowed.
- Async reset mid-LOAD or in RUN: all outputs return to reset values immediately; core_rst_no=0 without waiting for a clock.

## Test plan
- UART boot, 3 writes (addr 0,1,2; data 0x11, 0x22, 0x33), then uart_done -> mem writes 1 cycle later, word_count=3, checksum=0x66, DRAIN 4 cycles, core_rst_no=1, error_o=0.
- SPI boot with a UART write injected at addr 5 -> UART write not seen on mem_*, error_o=1, SPI writes proceed normally.
- Selected write at addr 16384 with DEPTH=16384 -> no mem write, word_count unchanged, error_o=1.
- Write and done in the same cycle (addr 7, data 0xFFFFFFFF after checksum 0x1) -> write issued, checksum=0x0 (wrap), state goes to DRAIN.
- RUN: core reads addr 0,1 back-to-back -> gnt same cycle, rvalid in cycles N+1 and N+2 carrying mem_rdata_i, mem_we_o=0.
- rst_ni pulsed low mid-LOAD after 2 writes -> word_count=0, checksum=0, core_rst_no=0 immediately; the next boot re-samples boot_sel_i.
